// File: rtl/adc_capture_ctrl_if.sv
// Capture RAM write port between the capture sequencer (master) and the sample buffer (slave).
interface adc_capture_ctrl_if #(
   parameter int unsigned ADDR_W = 10
);
   localparam int unsigned WORD_W = 48;

   logic              wr_en_o;
   logic [ADDR_W-1:0] wr_addr_o;
   logic [WORD_W-1:0] wr_data_o;

   modport master (output wr_en_o, output wr_addr_o, output wr_data_o);
   modport slave  (input  wr_en_o, input  wr_addr_o, input  wr_data_o);
endinterface

// File: rtl/adc_capture_ctrl.sv
// Capture sequencer for the dual-channel DDR ADC: arm, trigger, then write a
// decimated block of {B, A} words into the capture RAM.
module adc_capture_ctrl #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned HOLDOFF = 16
) (
   input  logic                 adc_clk_i,
   input  logic                 rst_i,
   input  logic [23:0]          data_a_i,
   input  logic [23:0]          data_b_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [1:0]           trig_mode_i,
   input  logic                 trig_ext_i,
   input  logic [11:0]          threshold_i,
   input  logic [ADDR_W-1:0]    length_i,
   input  logic [7:0]           decim_i,
   adc_capture_ctrl_if.master   wr,
   output logic                 busy_o,
   output logic                 armed_o,
   output logic                 done_o
);
   localparam int unsigned SAMPLE_W = 12;
   localparam int unsigned WORD_W   = 2 * SAMPLE_W;
   localparam int unsigned DECIM_W  = 8;
   localparam int unsigned HOLD_W   = $clog2(HOLDOFF);

   typedef enum logic [1:0] {IDLE, ARM, WAIT_TRIG, CAPTURE} state_t;

   state_t                      state;
   logic [WORD_W-1:0]           s1_a;
   logic [WORD_W-1:0]           s1_b;
   logic signed [SAMPLE_W-1:0]  prev_fall;
   logic                        trig_ext_q;
   logic [1:0]                  mode_q;
   logic signed [SAMPLE_W-1:0]  thr_q;
   logic [ADDR_W-1:0]           len_q;
   logic [DECIM_W-1:0]          decim_q;
   logic [HOLD_W-1:0]           hold_cnt;
   logic [DECIM_W-1:0]          decim_cnt;
   logic signed [SAMPLE_W-1:0]  a_rise;
   logic signed [SAMPLE_W-1:0]  a_fall;
   logic                        trig_fire;

   assign a_rise = s1_a[SAMPLE_W-1:0];
   assign a_fall = s1_a[WORD_W-1:SAMPLE_W];

   // Trigger qualifier; a sample equal to the threshold counts as crossed.
   always_comb begin
      trig_fire = 1'b0;
      case (mode_q)
         2'd1:    trig_fire = trig_ext_i & ~trig_ext_q;
         2'd2:    trig_fire = ((prev_fall < thr_q) && (a_rise >= thr_q)) ||
                              ((a_rise < thr_q) && (a_fall >= thr_q));
         default: trig_fire = 1'b1;
      endcase
   end

   always_ff @(posedge adc_clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         s1_a         <= '0;
         s1_b         <= '0;
         prev_fall    <= '0;
         trig_ext_q   <= 1'b0;
         mode_q       <= '0;
         thr_q        <= '0;
         len_q        <= '0;
         decim_q      <= '0;
         hold_cnt     <= '0;
         decim_cnt    <= '0;
         wr.wr_en_o   <= 1'b0;
         wr.wr_addr_o <= '0;
         wr.wr_data_o <= '0;
         busy_o       <= 1'b0;
         armed_o      <= 1'b0;
         done_o       <= 1'b0;
      end else begin
         s1_a       <= data_a_i;
         s1_b       <= data_b_i;
         prev_fall  <= s1_a[WORD_W-1:SAMPLE_W];
         trig_ext_q <= trig_ext_i;
         wr.wr_en_o <= 1'b0;

         if (abort_i) begin
            state   <= IDLE;
            busy_o  <= 1'b0;
            armed_o <= 1'b0;
            done_o  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_i) begin
                     mode_q   <= trig_mode_i;
                     thr_q    <= threshold_i;
                     len_q    <= length_i;
                     decim_q  <= decim_i;
                     hold_cnt <= HOLD_W'(HOLDOFF - 1);
                     done_o   <= 1'b0;
                     busy_o   <= 1'b1;
                     state    <= ARM;
                  end
               end
               ARM: begin
                  if (hold_cnt == '0) begin
                     armed_o <= 1'b1;
                     state   <= WAIT_TRIG;
                  end else begin
                     hold_cnt <= hold_cnt - 1'b1;
                  end
               end
               WAIT_TRIG: begin
                  // The word that fires the trigger becomes word 0.
                  if (trig_fire) begin
                     armed_o      <= 1'b0;
                     wr.wr_en_o   <= 1'b1;
                     wr.wr_addr_o <= '0;
                     wr.wr_data_o <= {s1_b, s1_a};
                     decim_cnt    <= decim_q;
                     state        <= CAPTURE;
                  end
               end
               CAPTURE: begin
                  if (wr.wr_en_o && (wr.wr_addr_o == len_q)) begin
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                     state  <= IDLE;
                  end else if (decim_cnt == '0) begin
                     wr.wr_en_o   <= 1'b1;
                     wr.wr_addr_o <= wr.wr_addr_o + 1'b1;
                     wr.wr_data_o <= {s1_b, s1_a};
                     decim_cnt    <= decim_q;
                  end else begin
                     decim_cnt <= decim_cnt - 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: timeline model of the acquisition checked
// every cycle, plus literal expectations for each scenario.
module tb_adc_capture_ctrl;
   localparam int unsigned ADDR_W  = 10;
   localparam int unsigned HOLDOFF = 16;
   localparam int unsigned MAXC    = 16384;
   localparam int unsigned MAXW    = 4096;

   logic              adc_clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic [23:0]       data_a_i = '0;
   logic [23:0]       data_b_i = '0;
   logic              start_i = 1'b0;
   logic              abort_i = 1'b0;
   logic [1:0]        trig_mode_i = '0;
   logic              trig_ext_i = 1'b0;
   logic [11:0]       threshold_i = '0;
   logic [ADDR_W-1:0] length_i = '0;
   logic [7:0]        decim_i = '0;
   logic              busy_o, armed_o, done_o;

   adc_capture_ctrl_if #(.ADDR_W(ADDR_W)) wr_if ();

   adc_capture_ctrl #(.ADDR_W(ADDR_W), .HOLDOFF(HOLDOFF)) dut (
      .adc_clk_i(adc_clk_i), .rst_i(rst_i), .data_a_i(data_a_i), .data_b_i(data_b_i),
      .start_i(start_i), .abort_i(abort_i), .trig_mode_i(trig_mode_i),
      .trig_ext_i(trig_ext_i), .threshold_i(threshold_i), .length_i(length_i),
      .decim_i(decim_i), .wr(wr_if), .busy_o(busy_o), .armed_o(armed_o), .done_o(done_o)
   );

   always #5 adc_clk_i = ~adc_clk_i;

   typedef struct packed {
      logic              rst;
      logic              start;
      logic              abort;
      logic              ext;
      logic [1:0]        mode;
      logic [11:0]       thr;
      logic [ADDR_W-1:0] len;
      logic [7:0]        dec;
      logic [23:0]       a;
      logic [23:0]       b;
   } in_t;

   in_t rec [MAXC];
   int  cyc = 0;
   int  n_assert = 0;
   int  n_fail = 0;
   bit  hold = 1'b0;

   // Acquisition timeline model
   int          m_active = 0, m_w = 0, m_trig = -1, m_count = 0, m_next = 0;
   int          m_len = 0, m_dec = 0, m_mode = 0;
   logic [11:0] m_thr = '0;
   logic        m_done = 1'b0;
   logic        exp_wr_en = 1'b0, exp_busy = 1'b0, exp_armed = 1'b0, exp_done = 1'b0;
   logic [ADDR_W-1:0] exp_addr = '0;
   logic [47:0] exp_data = '0;

   // Write log from the DUT, used by the literal checks
   int                wl_cyc  [MAXW];
   logic [47:0]       wl_data [MAXW];
   logic [ADDR_W-1:0] wl_addr [MAXW];
   int                wr_cnt = 0, done_rises = 0, done_rise_cyc = 0;
   logic              done_prev = 1'b0;

   function automatic logic [23:0] pat_a(int c);
      return 24'(c * 32'h9E37 + 32'h123);
   endfunction

   function automatic logic [23:0] pat_b(int c);
      return 24'((c * 32'h3B1) ^ 32'hA5A5A5);
   endfunction

   function automatic bit fires(int t);
      logic signed [11:0] rise, fall, prev, thr;
      rise = rec[t-1].a[11:0];
      fall = rec[t-1].a[23:12];
      prev = rec[t-2].a[23:12];
      thr  = m_thr;
      case (m_mode)
         1:       return rec[t].ext && !rec[t-1].ext;
         2:       return ((prev < thr) && (rise >= thr)) || ((rise < thr) && (fall >= thr));
         default: return 1'b1;
      endcase
   endfunction

   task automatic chk(string name, logic [47:0] act, logic [47:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Record inputs and advance the model at each edge
   initial forever begin
      in_t r;
      int  c;
      @(posedge adc_clk_i);
      r.rst = rst_i;   r.start = start_i;  r.abort = abort_i; r.ext = trig_ext_i;
      r.mode = trig_mode_i; r.thr = threshold_i; r.len = length_i; r.dec = decim_i;
      r.a = data_a_i;  r.b = data_b_i;
      rec[cyc] = r;
      cyc = cyc + 1;
      c = cyc;
      exp_wr_en = 1'b0;
      if (r.rst) begin
         m_active = 0; m_done = 1'b0; exp_addr = '0; exp_data = '0;
      end else if (r.abort) begin
         m_active = 0; m_done = 1'b0;
      end else if (m_active == 0) begin
         if (r.start) begin
            m_active = 1; m_done = 1'b0; m_w = c + HOLDOFF; m_trig = -1; m_count = 0;
            m_mode = int'(r.mode); m_thr = r.thr; m_len = int'(r.len); m_dec = int'(r.dec);
         end
      end else if (m_count == m_len + 1) begin
         m_active = 0; m_done = 1'b1;
      end else begin
         if (m_trig < 0 && (c - 1) >= m_w && fires(c - 1)) begin
            m_trig = c - 1; m_next = c;
         end
         if (m_trig >= 0 && c == m_next) begin
            exp_wr_en = 1'b1;
            exp_addr  = ADDR_W'(m_count);
            exp_data  = {rec[c-2].b, rec[c-2].a};
            m_count   = m_count + 1;
            m_next    = m_next + m_dec + 1;
         end
      end
      exp_busy  = (m_active != 0);
      exp_armed = (m_active != 0) && (m_trig < 0) && (c >= m_w);
      exp_done  = m_done;
   end

   // Compare DUT with the model and log writes, away from the active edge
   initial forever begin
      @(negedge adc_clk_i);
      if (cyc >= 1) begin
         chk("wr_en", 48'(wr_if.wr_en_o), 48'(exp_wr_en));
         chk("wr_addr", 48'(wr_if.wr_addr_o), 48'(exp_addr));
         chk("wr_data", wr_if.wr_data_o, exp_data);
         chk("busy", 48'(busy_o), 48'(exp_busy));
         chk("armed", 48'(armed_o), 48'(exp_armed));
         chk("done", 48'(done_o), 48'(exp_done));
         if (wr_if.wr_en_o === 1'b1 && wr_cnt < int'(MAXW)) begin
            wl_cyc[wr_cnt]  = cyc;
            wl_data[wr_cnt] = wr_if.wr_data_o;
            wl_addr[wr_cnt] = wr_if.wr_addr_o;
            wr_cnt = wr_cnt + 1;
         end
         if (done_o === 1'b1 && done_prev !== 1'b1) begin
            done_rises = done_rises + 1;
            done_rise_cyc = cyc;
         end
         done_prev = done_o;
      end
   end

   task automatic step();
      if (!hold) begin
         data_a_i = pat_a(cyc);
         data_b_i = pat_b(cyc);
      end
      @(posedge adc_clk_i);
      #1;
   endtask

   task automatic run_until(int target);
      while (cyc < target) step();
   endtask

   task automatic pulse_start(input logic [1:0] mode, input logic [11:0] thr,
                              input logic [ADDR_W-1:0] len, input logic [7:0] dec,
                              output int s, output int w0);
      trig_mode_i = mode; threshold_i = thr; length_i = len; decim_i = dec;
      start_i = 1'b1;
      s  = cyc;
      w0 = wr_cnt;
      step();
      start_i = 1'b0;
      trig_mode_i = ~mode; threshold_i = ~thr; length_i = ~len; decim_i = ~dec;
   endtask

   task automatic wait_idle(string name, int bound);
      int n = 0;
      while (busy_o === 1'b1 && n < bound) begin
         step();
         n++;
      end
      if (n >= bound) begin
         n_assert++;
         n_fail++;
         $display("FAIL %s cyc=%0d actual=busy_after_%0d_cycles expected=idle", name, cyc, bound);
      end
      repeat (3) step();
   endtask

   initial begin
      int s, w0;
      repeat (3) step();
      rst_i = 1'b0;
      step();
      chk("reset_busy", 48'(busy_o), 48'd0);
      chk("reset_done", 48'(done_o), 48'd0);

      // Mode 0, length 3: four back-to-back writes 18 cycles after start
      pulse_start(2'd0, 12'h000, 10'd3, 8'd0, s, w0);
      chk("t1_busy_rise", 48'(busy_o), 48'd1);
      wait_idle("t1_wait", 100);
      chk("t1_count", 48'(wr_cnt - w0), 48'd4);
      chk("t1_first_cyc", 48'(wl_cyc[w0]), 48'(s + 18));
      chk("t1_last_addr", 48'(wl_addr[w0+3]), 48'd3);
      chk("t1_done_cyc", 48'(done_rise_cyc), 48'(s + 22));

      // Mode 2, ramp crossing on the rise sample (rise == threshold)
      hold = 1'b1;
      data_a_i = 24'hF00F00;
      pulse_start(2'd2, 12'h100, 10'd3, 8'd0, s, w0);
      while (cyc < s + 40) begin
         int k;
         k = cyc - s - 20;
         if (k >= 0 && k <= 8) data_a_i = {12'(249 + 2 * k), 12'(248 + 2 * k)};
         data_b_i = pat_b(cyc);
         step();
      end
      wait_idle("t2_wait", 100);
      chk("t2_count", 48'(wr_cnt - w0), 48'd4);
      chk("t2_first_cyc", 48'(wl_cyc[w0]), 48'(s + 26));
      chk("t2_trig_word", 48'(wl_data[w0][23:0]), 48'h101100);

      // Mode 2, crossing on the fall sample (fall == threshold)
      data_a_i = 24'hF00F00;
      pulse_start(2'd2, 12'h100, 10'd3, 8'd0, s, w0);
      while (cyc < s + 40) begin
         int k;
         k = cyc - s - 20;
         if (k >= 0 && k <= 8) data_a_i = {12'(248 + 2 * k), 12'(247 + 2 * k)};
         data_b_i = pat_b(cyc);
         step();
      end
      wait_idle("t2b_wait", 100);
      chk("t2b_count", 48'(wr_cnt - w0), 48'd4);
      chk("t2b_trig_word", 48'(wl_data[w0][23:0]), 48'h1000FF);
      hold = 1'b0;

      // Mode 1, decim 2: ARM pulse ignored, pulse in WAIT_TRIG fires
      pulse_start(2'd1, 12'h000, 10'd7, 8'd2, s, w0);
      run_until(s + 5);
      trig_ext_i = 1'b1; step(); trig_ext_i = 1'b0;
      run_until(s + 22);
      trig_ext_i = 1'b1; step(); trig_ext_i = 1'b0;
      wait_idle("t3_wait", 100);
      chk("t3_count", 48'(wr_cnt - w0), 48'd8);
      chk("t3_first_data", wl_data[w0], {pat_b(s + 21), pat_a(s + 21)});
      for (int k = 0; k < 8; k++) begin
         chk("t3_wr_cyc", 48'(wl_cyc[w0+k]), 48'(s + 23 + 3 * k));
         chk("t3_wr_addr", 48'(wl_addr[w0+k]), 48'(k));
      end

      // Abort after the second write of a 16-word block
      pulse_start(2'd0, 12'h000, 10'd15, 8'd0, s, w0);
      run_until(s + 19);
      abort_i = 1'b1; step(); abort_i = 1'b0;
      chk("t4_busy", 48'(busy_o), 48'd0);
      chk("t4_done", 48'(done_o), 48'd0);
      wait_idle("t4_wait", 100);
      chk("t4_count", 48'(wr_cnt - w0), 48'd2);
      pulse_start(2'd0, 12'h000, 10'd1, 8'd0, s, w0);
      wait_idle("t4b_wait", 100);
      chk("t4b_count", 48'(wr_cnt - w0), 48'd2);
      chk("t4b_done", 48'(done_o), 48'd1);

      // Start with abort in IDLE is discarded; start during CAPTURE ignored
      start_i = 1'b1; abort_i = 1'b1; step(); start_i = 1'b0; abort_i = 1'b0;
      step();
      chk("t5_busy", 48'(busy_o), 48'd0);
      chk("t5_done", 48'(done_o), 48'd0);
      pulse_start(2'd0, 12'h000, 10'd5, 8'd0, s, w0);
      run_until(s + 20);
      trig_mode_i = 2'd2; length_i = '0; start_i = 1'b1; step(); start_i = 1'b0;
      wait_idle("t5_wait", 100);
      chk("t5_count", 48'(wr_cnt - w0), 48'd6);

      // Mode 3 behaves as immediate; decim 255 gives 256-cycle spacing
      pulse_start(2'd3, 12'h000, 10'd1, 8'd255, s, w0);
      wait_idle("t6_wait", 400);
      chk("t6_count", 48'(wr_cnt - w0), 48'd2);
      chk("t6_first_cyc", 48'(wl_cyc[w0]), 48'(s + 18));
      chk("t6_second_cyc", 48'(wl_cyc[w0+1]), 48'(s + 274));

      // Reset mid-capture leaves no completion flag
      pulse_start(2'd0, 12'h000, 10'd15, 8'd0, s, w0);
      run_until(s + 20);
      rst_i = 1'b1; step(); rst_i = 1'b0;
      chk("t7_busy", 48'(busy_o), 48'd0);
      chk("t7_addr", 48'(wr_if.wr_addr_o), 48'd0);
      wait_idle("t7_wait", 100);
      chk("t7_count", 48'(wr_cnt - w0), 48'd3);
      chk("t7_done", 48'(done_o), 48'd0);

      // Full-size block reaches address 0x3FF without wrapping
      begin
         int d0;
         d0 = done_rises;
         pulse_start(2'd0, 12'h000, 10'h3FF, 8'd0, s, w0);
         wait_idle("t8_wait", 1200);
         chk("t8_count", 48'(wr_cnt - w0), 48'd1024);
         chk("t8_last_addr", 48'(wl_addr[w0+1023]), 48'h3FF);
         chk("t8_last_cyc", 48'(wl_cyc[w0+1023]), 48'(s + 1041));
         chk("t8_done_once", 48'(done_rises - d0), 48'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Capture sequencer for the dual-channel DDR ADC front end.
- Consumes the 24-bit per-clock words of channels A and B: {fall[11:0], rise[11:0]}, two 12-bit samples per clock, rise earlier in time.
- Arms on command, waits for an immediate, external or threshold trigger, then writes a decimated block of samples into a capture RAM through a simple write port.
- Sits between the ADC input block and the sample buffer BRAM; software controls it through configuration-register ports.

Parameters:
- ADDR_W, 10, capture RAM address width; maximum block length is 2^ADDR_W words.
- HOLDOFF, 16, cycles spent in ARM before triggers are accepted (primes the pipeline and previous-sample history); must be >= 2.

Ports:
- adc_clk_i  in  1  ADC clock; all logic runs on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- data_a_i  in  24  channel A word {fall, rise}; 12-bit two's-complement samples.
- data_b_i  in  24  channel B word {fall, rise}.
- start_i  in  1  single-cycle pulse; starts an acquisition from IDLE.
- abort_i  in  1  level or pulse; aborts the acquisition.
- trig_mode_i  in  2  0 = immediate, 1 = external rising edge, 2 = channel A threshold rising crossing, 3 = treated as 0.
- trig_ext_i  in  1  external trigger, synchronous to adc_clk_i.
- threshold_i  in  12  signed threshold.
- length_i  in  ADDR_W  number of words to capture, minus 1.
- decim_i  in  8  write every (decim_i+1)-th word; 0 = every word.
- wr_en_o  out  1  RAM write strobe.
- wr_addr_o  out  ADDR_W  RAM write address.
- wr_data_o  out  48  written word {B[23:0], A[23:0]}.
- busy_o  out  1  high in ARM, WAIT_TRIG and CAPTURE.
- armed_o  out  1  high in WAIT_TRIG only.
- done_o  out  1  sticky completion flag.

Behaviour:
Reset:
- All outputs 0; state IDLE; all internal registers 0.

Pipeline:
- data_a_i and data_b_i are registered every cycle into S1.
- prev_fall holds S1.A fall from the previous cycle.
- trig_ext_q holds trig_ext_i delayed one cycle.

Configuration latching:
- trig_mode, threshold, length and decim are captured on the accepted start_i.
- Changes to these inputs during an acquisition have no effect.

States:
- IDLE: on start_i with abort_i low:
  - latch configuration;
  - clear done_o;
  - load holdoff counter with HOLDOFF-1;
  - go to ARM.
- ARM: decrement the counter; when it is 0, go to WAIT_TRIG. Triggers are ignored in this state.
- WAIT_TRIG: evaluate the trigger each cycle; when it fires in cycle t, go to CAPTURE at t+1.
  - Mode 0: fires in the first WAIT_TRIG cycle.
  - Mode 1: fires when trig_ext_i & ~trig_ext_q.
  - Mode 2: fires when (prev_fall < thr AND S1.A.rise >= thr) OR (S1.A.rise < thr AND S1.A.fall >= thr). All comparisons are signed.
- CAPTURE:
  - Cycle t+1: wr_en_o=1, wr_addr_o=0, wr_data_o = S1 contents at cycle t (the trigger word is word 0).
  - Decimation counter reloads to decim; each subsequent write occurs exactly decim+1 cycles after the previous one, with wr_data_o = S1 of the preceding cycle.
  - wr_addr_o increments by 1 per write.
  - After the write with address == length, go to IDLE. done_o rises the cycle after that last write; busy_o falls in the same cycle.
  - Total writes = length+1; with decim = 0 they occur on consecutive cycles.

Output rules:
- wr_en_o is high only in CAPTURE write cycles; otherwise 0.
- wr_addr_o and wr_data_o hold their last value when wr_en_o is low.
- done_o stays high until the next accepted start_i, an abort_i, or rst_i.

Abort and start interactions:
- abort_i in any state: next state IDLE; wr_en_o=0 from the next cycle; done_o=0; busy_o=0 next cycle. No further writes occur.
- start_i and abort_i in the same cycle: abort wins; the start is discarded.
- start_i while busy_o=1 is ignored.
- rst_i mid-capture: immediate return to reset values on the next edge; no partial-completion flag.

Boundary conditions:
- length = 0: exactly one write.
- length = 2^ADDR_W-1: the address reaches the all-ones value with no wrap, then the block completes.
- decim = 255: 256-cycle write spacing.
- Mode 2 when a sample equals thr: counts as >= thr.
- Mode 2 with both rise and fall crossing conditions true in one cycle: a single trigger.

Test Plan:
- Reset then start, mode 0, length=3, decim=0, HOLDOFF=16 -> busy_o rises 1 cycle after start; 4 consecutive writes at addr 0..3 beginning 18 cycles after start; done_o=1 the cycle after addr 3; busy_o=0.
- Mode 2, thr=0x100, ramp A rise/fall = -8..+8 step 1 per sample around 0x100 -> trigger word is the one whose rise or fall first reaches 0x100; it is written at addr 0; exactly one trigger.
- Mode 1, length=7, decim=2, trig_ext_i pulses during ARM and again 5 cycles into WAIT_TRIG -> ARM pulse ignored; 8 writes spaced 3 cycles apart, addresses 0..7; data equals the S1 words sampled at those instants.
- abort_i asserted after the 2nd write of a length=15 capture -> no further writes; busy_o=0 and done_o=0 next cycle; a subsequent start works normally.
- start_i and abort_i together in IDLE -> stays IDLE; start_i during CAPTURE -> ignored, writes unaffected.
- length=2^ADDR_W-1, decim=0, mode 0 -> 1024 writes, final addr 0x3FF, no wrap, done_o set once.
